// File: rtl/x_stream_serializer.sv
// Parallel-to-serial feeder for the sequence detector: valid/ready word input,
// one-word holding register, gapless bit stream on x with frame markers.
module x_stream_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic             hold_full;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             out_bit;
  logic [WIDTH-1:0] sr_shifted;

  assign in_ready   = !hold_full && !rst;
  assign accept     = in_valid && in_ready;
  assign out_bit    = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  assign sr_shifted = MSB_FIRST ? (sr << 1) : (sr >> 1);

  // NOTE: the holding data needs no reset; hold_full alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (accept) hold_q <= in_data;
  end

  // Outputs are registered from the current shifter state, so x lags the
  // load edge by one cycle and the markers stay aligned with x.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_full   <= 1'b0;
      sr          <= '0;
      cnt         <= '0;
      x           <= IDLE_BIT;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
      words_sent  <= '0;
    end else begin
      x_valid     <= (state == SHIFT);
      x           <= (state == SHIFT) ? out_bit : IDLE_BIT;
      frame_start <= (state == SHIFT) && (cnt == '0);
      frame_end   <= (state == SHIFT) && (cnt == LAST);
      busy        <= (state == SHIFT) || hold_full;

      case (state)
        IDLE: begin
          if (hold_full) begin
            sr        <= hold_q;
            cnt       <= '0;
            hold_full <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            words_sent <= words_sent + 16'd1;
            cnt        <= '0;
            if (hold_full) begin
              sr        <= hold_q;
              hold_full <= 1'b0;
            end else begin
              sr    <= sr_shifted;
              state <= IDLE;
            end
          end else begin
            sr  <= sr_shifted;
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // accept requires hold_full==0, so it never collides with a load clearing it
      if (accept) hold_full <= 1'b1;
    end
  end

endmodule
